// File: rtl/karatsuba_seq_ctrl.sv
// Sequential Karatsuba multiplier: one shared (HALF+1)x(HALF+1) multiplier
// runs ac, bd and (a+b)(c+d) in turn, then forms the full 2*WIDTH product.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake for X, Y (WIDTH bits, unsigned)
//   out_valid, out_ready result handshake for Z (2*WIDTH bits)
//   busy                high whenever the scheduler is not idle
module karatsuba_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Z,
  output logic               busy
);

  localparam int HALF = WIDTH / 2;
  localparam int HP   = HALF + 1;
  localparam int PW   = 2 * HALF + 2;
  localparam int ZW   = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    MUL_AC,
    MUL_BD,
    MUL_MID,
    DONE
  } state_t;

  state_t state, state_n;

  logic [HALF-1:0] a, b, c, d;
  logic [PW-1:0]   m1, m2;
  logic [ZW-1:0]   z;

  logic [HP-1:0]   sa, sc;
  logic [HP-1:0]   mul_x, mul_y;
  logic [PW-1:0]   prod;
  logic [PW-1:0]   mid;
  logic [ZW-1:0]   z_n;

  // Sums keep their carry bit so (a+b)(c+d) is exact.
  assign sa = HP'(a) + HP'(b);
  assign sc = HP'(c) + HP'(d);

  always_comb begin
    mul_x = '0;
    mul_y = '0;
    unique case (state)
      MUL_AC: begin
        mul_x = HP'(a);
        mul_y = HP'(c);
      end
      MUL_BD: begin
        mul_x = HP'(b);
        mul_y = HP'(d);
      end
      MUL_MID: begin
        mul_x = sa;
        mul_y = sc;
      end
      default: begin
        mul_x = '0;
        mul_y = '0;
      end
    endcase
  end

  assign prod = PW'(mul_x) * PW'(mul_y);

  // Middle term equals ad+bc, so it never goes negative.
  assign mid = prod - m1 - m2;

  assign z_n = (ZW'(m1) << WIDTH)
             + (ZW'(mid) << HALF)
             + ZW'(m2);

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_n = MUL_AC;
      end
      MUL_AC:  state_n = MUL_BD;
      MUL_BD:  state_n = MUL_MID;
      MUL_MID: state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      d     <= '0;
      m1    <= '0;
      m2    <= '0;
      z     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        a <= X[WIDTH-1:HALF];
        b <= X[HALF-1:0];
        c <= Y[WIDTH-1:HALF];
        d <= Y[HALF-1:0];
      end
      if (state == MUL_AC)  m1 <= prod;
      if (state == MUL_BD)  m2 <= prod;
      if (state == MUL_MID) z  <= z_n;
    end
  end

  assign Z = z;

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Directed bench for karatsuba_seq_ctrl: reset, latency, corner operands,
// backpressure, mid-operation reset and a streamed back-to-back run.
module tb_karatsuba_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] X;
  logic [15:0] Y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Z;
  logic        busy;

  int errors = 0;
  int checks = 0;

  karatsuba_seq_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one pair with out_ready high; verify latency, result, release.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        input logic [31:0] exp, input string tag);
    @(negedge clk);
    X         = x;
    Y         = y;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, " accept_ready"}, 32'(in_ready), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      X        = 16'hDEAD;
      Y        = 16'hBEEF;
      check({tag, " early_valid"}, 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check({tag, " valid_at_4"}, 32'(out_valid), 32'd1);
    check({tag, " Z"}, Z, exp);
    @(negedge clk);
    check({tag, " back_idle"}, 32'(in_ready), 32'd1);
    check({tag, " valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] want;
  int          sent;
  int          got;
  int          budget;
  logic        load;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    X         = '0;
    Y         = '0;
    void'($urandom(32'h1234));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and quiet idle.
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst Z", Z, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);
    check("idle out_valid", 32'(out_valid), 32'd0);
    check("idle in_ready", 32'(in_ready), 32'd1);

    // Directed products.
    run_op(16'h1234, 16'h5678, 32'h06260060, "p1234");
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "pFFFF");
    run_op(16'h00FF, 16'h0100, 32'h0000FF00, "p00FF");
    run_op(16'h0000, 16'hABCD, 32'h00000000, "pzero");

    // Backpressure: result held, new in_valid ignored.
    @(negedge clk);
    X         = 16'h8001;
    Y         = 16'h0003;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    X = 16'h7777;
    Y = 16'h7777;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check("bp valid", 32'(out_valid), 32'd1);
      check("bp Z", Z, 32'h00018003);
      check("bp in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("bp release Z", Z, 32'h00018003);
    @(negedge clk);
    check("bp released", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("bp not captured", 32'(busy), 32'd0);

    // Reset while in MUL_BD.
    X         = 16'h1111;
    Y         = 16'h2222;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst Z", Z, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("mid no valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    run_op(16'd3, 16'd5, 32'd15, "p3x5");

    // Streamed run: in_valid held high, random out_ready.
    sent   = 0;
    got    = 0;
    budget = 0;
    load   = 1'b1;
    while ((sent < 20 || got < 20) && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (load) begin
        X    = 16'($urandom);
        Y    = 16'($urandom);
        load = 1'b0;
      end
      in_valid  = (sent < 20);
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("b2b spurious", 32'd1, 32'd0);
        end else begin
          want = exp_q.pop_front();
          check("b2b Z", Z, want);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(32'(X) * 32'(Y));
        sent++;
        load = 1'b1;
      end
    end
    check("b2b timeout", 32'(budget < 1000), 32'd1);
    check("b2b count", 32'(got), 32'd20);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
